// File: rtl/cam_stream_ctrl_if.sv
// cam_stream_ctrl_if: control, FIFO-read and pixel-stream signals of the camera sequencer
interface cam_stream_ctrl_if;
    logic        i_enable;
    logic        o_cfg_init;
    logic        i_cfg_done;
    logic        i_sof;
    logic        o_obuf_rd;
    logic [11:0] i_obuf_data;
    logic        i_obuf_empty;
    logic        o_pix_valid;
    logic        i_pix_ready;
    logic [11:0] o_pix_data;
    logic [9:0]  o_pix_x;
    logic [8:0]  o_pix_y;
    logic        o_frame_done;
    logic [1:0]  o_err;
    logic [2:0]  o_state;

    modport master (
        input  i_enable, i_cfg_done, i_sof, i_obuf_data, i_obuf_empty, i_pix_ready,
        output o_cfg_init, o_obuf_rd, o_pix_valid, o_pix_data, o_pix_x, o_pix_y,
               o_frame_done, o_err, o_state
    );

    modport slave (
        output i_enable, i_cfg_done, i_sof, i_obuf_data, i_obuf_empty, i_pix_ready,
        input  o_cfg_init, o_obuf_rd, o_pix_valid, o_pix_data, o_pix_x, o_pix_y,
               o_frame_done, o_err, o_state
    );
endinterface

// File: rtl/cam_stream_ctrl.sv
// cam_stream_ctrl: camera bring-up sequencer and FIFO-to-pixel-stream drain with x/y tagging
module cam_stream_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PWRUP_CYCLES = 1000,
    parameter int CFG_TIMEOUT  = 1048576,
    parameter int CFG_RETRIES  = 3
) (
    input logic             i_clk,
    input logic             i_rstn,
    cam_stream_ctrl_if.master bus
);
    localparam int PW = $clog2(PWRUP_CYCLES + 1);
    localparam int TW = $clog2(CFG_TIMEOUT + 1);
    localparam int RW = $clog2(CFG_RETRIES + 1);

    typedef enum logic [2:0] {
        PWRUP    = 3'd0,
        CFG      = 3'd1,
        WAIT_SOF = 3'd2,
        STREAM   = 3'd3,
        HALT     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic        cfg_init_q, cfg_init_d;
    logic        sof_q;
    logic [1:0]  cnt_q, cnt_d;
    logic        infl_q, infl_d;
    logic [11:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;

    logic        sof_edge, pix_valid, accept, x_last, complete, flush, rd;
    logic [1:0]  occ;

    assign sof_edge  = bus.i_sof & ~sof_q;
    // The word arriving from the FIFO is presented directly when the skid buffer is empty.
    assign pix_valid = (cnt_q != 2'd0) || infl_q;
    assign accept    = pix_valid && bus.i_pix_ready;
    assign x_last    = x_q == 10'(H_ACTIVE - 1);
    assign complete  = accept && x_last && (y_q == 9'(V_ACTIVE - 1));
    assign flush     = (state_q == STREAM) && (complete || sof_edge);
    assign occ       = cnt_q + {1'b0, infl_q} - {1'b0, accept};
    assign rd        = (state_q == WAIT_SOF) ? !bus.i_obuf_empty :
                       (state_q == STREAM)   ? (!bus.i_obuf_empty && occ < 2'd2) : 1'b0;

    always_comb begin
        state_d    = state_q;
        pwr_d      = pwr_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        cfg_init_d = 1'b0;
        err_d      = err_q;
        done_d     = complete;
        case (state_q)
            PWRUP: begin
                if (pwr_q == PW'(PWRUP_CYCLES - 1)) begin
                    state_d    = CFG;
                    cfg_init_d = 1'b1;
                    tmo_d      = '0;
                end else begin
                    pwr_d = pwr_q + PW'(1);
                end
            end
            CFG: begin
                if (bus.i_cfg_done) begin
                    state_d = WAIT_SOF;
                end else if (tmo_q == TW'(CFG_TIMEOUT - 1)) begin
                    retry_d = retry_q + RW'(1);
                    tmo_d   = '0;
                    if (retry_q + RW'(1) < RW'(CFG_RETRIES)) begin
                        cfg_init_d = 1'b1;
                    end else begin
                        err_d[0] = 1'b1;
                        state_d  = HALT;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_SOF: state_d = (sof_edge && bus.i_enable) ? STREAM : WAIT_SOF;
            STREAM: begin
                // A final accept wins over a coincident SOF, which then opens the next frame.
                if (complete) begin
                    state_d = (sof_edge && bus.i_enable) ? STREAM : WAIT_SOF;
                end else if (sof_edge) begin
                    err_d[1] = 1'b1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = PWRUP;
        endcase
    end

    always_comb begin
        cnt_d  = flush ? 2'd0 : occ;
        infl_d = (state_q == STREAM) && rd && !flush;
        buf0_d = (infl_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && accept))) ? bus.i_obuf_data :
                 (cnt_q == 2'd2 && accept) ? buf1_q : buf0_q;
        buf1_d = (infl_q && cnt_q == 2'd1 && !accept) ? bus.i_obuf_data : buf1_q;
        x_d    = flush ? 10'd0 : accept ? (x_last ? 10'd0 : x_q + 10'd1) : x_q;
        y_d    = flush ? 9'd0 : (accept && x_last) ? y_q + 9'd1 : y_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= PWRUP;
            pwr_q      <= '0;
            tmo_q      <= '0;
            retry_q    <= '0;
            cfg_init_q <= 1'b0;
            sof_q      <= 1'b0;
            cnt_q      <= 2'd0;
            infl_q     <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            pwr_q      <= pwr_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            cfg_init_q <= cfg_init_d;
            sof_q      <= bus.i_sof;
            cnt_q      <= cnt_d;
            infl_q     <= infl_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            x_q        <= x_d;
            y_q        <= y_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_cfg_init   = cfg_init_q;
    assign bus.o_obuf_rd    = rd;
    assign bus.o_pix_valid  = pix_valid;
    assign bus.o_pix_data   = pix_valid ? ((cnt_q != 2'd0) ? buf0_q : bus.i_obuf_data) : 12'd0;
    assign bus.o_pix_x      = x_q;
    assign bus.o_pix_y      = y_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_err        = err_q;
    assign bus.o_state      = state_q;
endmodule
